// File: rtl/btb_update_pkg.sv
// Shared types and constants for the 2-way, 8-set branch target buffer.
// A set is two 64-bit ways packed as {way0, way1}.
package btb_update_pkg;

  localparam int SETS    = 8;
  localparam int INDEX_W = 3;
  localparam int TAG_W   = 27;
  localparam int WAY_W   = 64;
  localparam int SET_W   = 2 * WAY_W;

  localparam logic [1:0] STRONG_NOT_TAKEN = 2'b00;
  localparam logic [1:0] WEAK_NOT_TAKEN   = 2'b01;
  localparam logic [1:0] WEAK_TAKEN       = 2'b11;
  localparam logic [1:0] STRONG_TAKEN     = 2'b10;

  // Way field bit positions, kept for code that slices raw set vectors
  localparam int WAY_V_BIT      = 63;
  localparam int WAY_TAG_HI     = 62;
  localparam int WAY_TAG_LO     = 36;
  localparam int WAY_TARGET_HI  = 35;
  localparam int WAY_TARGET_LO  = 4;
  localparam int WAY_STATE_HI   = 3;
  localparam int WAY_STATE_LO   = 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       state;
    logic [1:0]       pad;
  } btb_way_t;

endpackage

// File: rtl/btb_update_if.sv
// Resolved-branch update channel from EX into the BTB write side.
interface btb_update_if;
  import btb_update_pkg::*;

  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;

  modport master (
    output upd_valid, upd_pc, upd_target, upd_taken,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_pc, upd_target, upd_taken,
    output upd_ready
  );

endinterface

// File: rtl/btb_update_counter_next.sv
// 2-bit direction counter step: 00 <-> 01 <-> 11 <-> 10, saturating at both ends.
// Encoding-agnostic callers can reuse this for any future predictor table.
module btb_counter_next
  import btb_update_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next_state
);

  always_comb begin
    next_state = state;
    case (state)
      STRONG_NOT_TAKEN: next_state = taken ? WEAK_NOT_TAKEN : STRONG_NOT_TAKEN;
      WEAK_NOT_TAKEN:   next_state = taken ? WEAK_TAKEN     : STRONG_NOT_TAKEN;
      WEAK_TAKEN:       next_state = taken ? STRONG_TAKEN   : WEAK_NOT_TAKEN;
      STRONG_TAKEN:     next_state = taken ? STRONG_TAKEN   : WEAK_TAKEN;
      default:          next_state = state;
    endcase
  end

endmodule

// File: rtl/btb_update.sv
// BTB storage owner: combinational IF read port, registered EX update with
// read-modify-write one cycle later, and an 8-cycle invalidate-all sequence.
module btb_update
  import btb_update_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_index,
  output logic [SET_W-1:0]   rd_set,
  output logic [SETS-1:0]    rd_lru,
  input  logic               if_lru_we,
  input  logic [INDEX_W-1:0] if_lru_index,
  input  logic               if_lru_val,
  btb_update_if.slave        upd_bus,
  input  logic               flush_req,
  output logic               flush_busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]         state;
  logic [INDEX_W-1:0] flush_cnt;

  logic [SET_W-1:0]   sets [SETS];
  logic [SETS-1:0]    lru;

  logic               s1_valid;
  logic [31:2]        s1_pc;
  logic [31:0]        s1_target;
  logic               s1_taken;

  logic               upd_ready;
  logic               accept;

  logic [INDEX_W-1:0] s2_index;
  logic [TAG_W-1:0]   s2_tag;
  logic [SET_W-1:0]   cur_set;
  btb_way_t           way0;
  btb_way_t           way1;
  btb_way_t           hit_entry;
  btb_way_t           new_entry;
  logic               hit0;
  logic               hit1;
  logic               alloc_way;
  logic               wr_way;
  logic               s2_write;
  logic [1:0]         cnt_next;
  logic [SET_W-1:0]   new_set;
  logic               if_lru_apply;

  assign upd_ready         = (state == ST_IDLE) && !flush_req;
  assign upd_bus.upd_ready = upd_ready;
  assign accept            = upd_bus.upd_valid && upd_ready;
  assign flush_busy        = (state == ST_FLUSH);

  assign rd_set = sets[rd_index];
  assign rd_lru = lru;

  btb_counter_next u_counter_next (
    .state      (hit_entry.state),
    .taken      (s1_taken),
    .next_state (cnt_next)
  );

  // S2 reads the committed array, so back-to-back updates to one set need no forwarding
  always_comb begin
    s2_index  = s1_pc[4:2];
    s2_tag    = s1_pc[31:5];
    cur_set   = sets[s2_index];
    way0      = btb_way_t'(cur_set[SET_W-1:WAY_W]);
    way1      = btb_way_t'(cur_set[WAY_W-1:0]);
    hit0      = way0.valid && (way0.tag == s2_tag);
    hit1      = way1.valid && (way1.tag == s2_tag);
    hit_entry = hit0 ? way0 : way1;

    if (!way0.valid)      alloc_way = 1'b0;
    else if (!way1.valid) alloc_way = 1'b1;
    else                  alloc_way = !lru[s2_index];

    new_entry = hit_entry;
    if (hit0 || hit1) begin
      wr_way          = hit1 && !hit0;
      new_entry.state = cnt_next;
      if (s1_taken) new_entry.target = s1_target;
    end else begin
      wr_way           = alloc_way;
      new_entry.valid  = 1'b1;
      new_entry.tag    = s2_tag;
      new_entry.target = s1_target;
      new_entry.state  = WEAK_TAKEN;
    end
    new_entry.pad = 2'b00;

    new_set = cur_set;
    if (wr_way) new_set[WAY_W-1:0]     = new_entry;
    else        new_set[SET_W-1:WAY_W] = new_entry;

    s2_write     = s1_valid && (hit0 || hit1 || s1_taken);
    if_lru_apply = if_lru_we && !(s2_write && (if_lru_index == s2_index));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_pc     <= '0;
      s1_target <= '0;
      s1_taken  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_pc     <= upd_bus.upd_pc[31:2];
        s1_target <= upd_bus.upd_target;
        s1_taken  <= upd_bus.upd_taken;
      end
    end
  end

  // EX writes win over the IF-stage LRU refresh; flush owns the array outright
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
      lru       <= '0;
      for (int i = 0; i < SETS; i++) sets[i] <= '0;
    end else if (state == ST_FLUSH) begin
      sets[flush_cnt] <= '0;
      lru[flush_cnt]  <= 1'b0;
      flush_cnt       <= flush_cnt + 3'd1;
      if (flush_cnt == 3'd7) state <= ST_IDLE;
    end else begin
      if (s2_write) begin
        sets[s2_index] <= new_set;
        lru[s2_index]  <= wr_way;
      end
      if (if_lru_apply) lru[if_lru_index] <= if_lru_val;
      if (flush_req) begin
        state     <= ST_FLUSH;
        flush_cnt <= '0;
      end
    end
  end

endmodule
